// File: rtl/rx_frame_writer.sv
// Writes MAC RX frames qword-by-qword into the 1024-qword ring, one length header per frame,
// and publishes the commit pointer only for complete good frames. Drop counter: RX_DROP_COUNTER_EN.
module rx_frame_writer #(
    parameter int unsigned MAX_FRAME_BYTES = 1522
) (
    input  logic        clk156,
    input  logic        reset_n,
    input  logic [63:0] rx_data,
    input  logic [7:0]  rx_data_valid,
    input  logic        rx_good_frame,
    input  logic        rx_bad_frame,
    input  logic [9:0]  commited_rd_address,
    output logic        wr_en,
    output logic [9:0]  wr_addr,
    output logic [63:0] wr_data,
    output logic [9:0]  commited_wr_address,
    output logic [31:0] dropped_frames
);

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 64;
    localparam int unsigned CW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_DROP,
        S_HDR,
        S_COMMIT
    } state_t;

    state_t        state;
    logic [AW-1:0] start;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] byte_count;

    logic [3:0]    pop_c;
    logic [CW:0]   count_next_c;
    logic [AW-1:0] idle_addr_c;
    logic [AW-1:0] data_addr_c;
    logic          idle_fits_c;
    logic          data_fits_c;
    logic          word_valid_c;
    logic          oversize_c;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

    // Next write slot and the one-empty-slot fit test against the read pointer.
    always_comb begin
        pop_c        = popcount8(rx_data_valid);
        count_next_c = {1'b0, byte_count} + (CW+1)'(pop_c);
        oversize_c   = count_next_c > (CW+1)'(MAX_FRAME_BYTES);
        word_valid_c = rx_data_valid != 8'd0;
        idle_addr_c  = commited_wr_address + AW'(1);
        data_addr_c  = wr_ptr + AW'(1);
        idle_fits_c  = (idle_addr_c + AW'(1)) != commited_rd_address;
        data_fits_c  = (data_addr_c + AW'(1)) != commited_rd_address;
    end

    always_ff @(posedge clk156 or negedge reset_n) begin
        if (!reset_n) begin
            state               <= S_IDLE;
            start               <= '0;
            wr_ptr              <= '0;
            byte_count          <= '0;
            wr_en               <= 1'b0;
            wr_addr             <= '0;
            wr_data             <= '0;
            commited_wr_address <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Rewinding wr_ptr here is what rolls back a dropped frame.
                    start  <= commited_wr_address;
                    wr_ptr <= commited_wr_address;
                    if (word_valid_c) begin
                        if (idle_fits_c) begin
                            wr_en      <= 1'b1;
                            wr_addr    <= idle_addr_c;
                            wr_data    <= rx_data;
                            wr_ptr     <= idle_addr_c;
                            byte_count <= CW'(pop_c);
                            state      <= S_DATA;
                        end else begin
                            state <= S_DROP;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_bad_frame) begin
                        wr_ptr <= start;
                        state  <= S_IDLE;
                    end else if (rx_good_frame) begin
                        state <= S_HDR;
                    end else if (word_valid_c) begin
                        if (!data_fits_c || oversize_c) begin
                            state <= S_DROP;
                        end else begin
                            wr_en      <= 1'b1;
                            wr_addr    <= data_addr_c;
                            wr_data    <= rx_data;
                            wr_ptr     <= data_addr_c;
                            byte_count <= count_next_c[CW-1:0];
                        end
                    end
                end
                S_DROP: begin
                    if (rx_good_frame || rx_bad_frame) begin
                        state <= S_IDLE;
                    end
                end
                S_HDR: begin
                    wr_en   <= 1'b1;
                    wr_addr <= start;
                    wr_data <= {{(DW-CW){1'b0}}, byte_count};
                    state   <= S_COMMIT;
                end
                S_COMMIT: begin
                    commited_wr_address <= wr_ptr + AW'(1);
                    state               <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RX_DROP_COUNTER_EN
    logic drop_event_c;

    // One increment per discarded frame, taken at its status pulse.
    assign drop_event_c = ((state == S_DATA) && rx_bad_frame) ||
                          ((state == S_DROP) && (rx_good_frame || rx_bad_frame));

    always_ff @(posedge clk156 or negedge reset_n) begin
        if (!reset_n) begin
            dropped_frames <= '0;
        end else if (drop_event_c) begin
            dropped_frames <= dropped_frames + 32'd1;
        end
    end
`else
    assign dropped_frames = '0;
`endif

endmodule

// File: tb/tb_rx_frame_writer.sv
// Scoreboard bench for rx_frame_writer: a frame-level ring model queues expected writes/commits,
// and a monitor pops and compares them as the DUT produces them.
module tb_rx_frame_writer;

    localparam int unsigned MAXB = 1522;

    logic        clk156;
    logic        reset_n;
    logic [63:0] rx_data;
    logic [7:0]  rx_data_valid;
    logic        rx_good_frame;
    logic        rx_bad_frame;
    logic [9:0]  commited_rd_address;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [9:0]  commited_wr_address;
    logic [31:0] dropped_frames;

    rx_frame_writer #(.MAX_FRAME_BYTES(MAXB)) dut (
        .clk156              (clk156),
        .reset_n             (reset_n),
        .rx_data             (rx_data),
        .rx_data_valid       (rx_data_valid),
        .rx_good_frame       (rx_good_frame),
        .rx_bad_frame        (rx_bad_frame),
        .commited_rd_address (commited_rd_address),
        .wr_en               (wr_en),
        .wr_addr             (wr_addr),
        .wr_data             (wr_data),
        .commited_wr_address (commited_wr_address),
        .dropped_frames      (dropped_frames)
    );

    initial clk156 = 1'b0;
    always #3 clk156 = ~clk156;

    typedef struct {
        bit          is_commit;
        logic [9:0]  addr;
        logic [63:0] data;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [9:0]  m_start = 10'd0;
    int unsigned m_drops = 0;
    logic [9:0]  prev_cwa = 10'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] exp_drops();
`ifdef RX_DROP_COUNTER_EN
        return 32'(m_drops);
`else
        return 32'd0;
`endif
    endfunction

    // Monitor: every ring write and every commit-pointer move must match the next queued event.
    initial begin
        ev_t ev;
        forever begin
            @(posedge clk156);
            #1;
            if (!reset_n) begin
                prev_cwa = 10'd0;
            end else begin
                if (wr_en) begin
                    check("write_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        ev = exp_q.pop_front();
                        check("event_is_write", 64'(ev.is_commit), 64'd0);
                        check("wr_addr", 64'(wr_addr), 64'(ev.addr));
                        check("wr_data", wr_data, ev.data);
                    end
                end
                if (commited_wr_address != prev_cwa) begin
                    check("commit_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        ev = exp_q.pop_front();
                        check("event_is_commit", 64'(ev.is_commit), 64'd1);
                        check("commited_wr_address", 64'(commited_wr_address), 64'(ev.addr));
                    end
                end
                prev_cwa = commited_wr_address;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk156);
        reset_n       = 1'b0;
        rx_data_valid = 8'd0;
        rx_good_frame = 1'b0;
        rx_bad_frame  = 1'b0;
        @(posedge clk156);
        #1;
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", wr_data, 64'd0);
        check("rst_commit", 64'(commited_wr_address), 64'd0);
        check("rst_dropped", 64'(dropped_frames), 64'd0);
        check("rst_queue_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        m_start = 10'd0;
        m_drops = 0;
        repeat (2) @(negedge clk156);
        reset_n = 1'b1;
        repeat (2) @(negedge clk156);
    endtask

    // Drives one frame; the ring model decides which words land, whether it commits and where.
    task automatic send_frame(input int nbytes, input bit good, input int abort_words);
        int          nw;
        int          nb;
        int          acc;
        bit          dropped;
        logic [9:0]  a;
        logic [63:0] d;
        nw      = (nbytes + 7) / 8;
        acc     = 0;
        dropped = 1'b0;
        for (int k = 1; k <= nw; k++) begin
            if (abort_words > 0 && k > abort_words) break;
            nb = (k == nw) ? nbytes - 8 * (nw - 1) : 8;
            if (k > 1 && $urandom_range(0, 5) == 0) begin
                @(negedge clk156);
                rx_data_valid = 8'd0;
                rx_data       = {$urandom, $urandom};
            end
            d = {$urandom, $urandom};
            @(negedge clk156);
            rx_data       = d;
            rx_data_valid = 8'((16'd1 << nb) - 16'd1);
            acc += nb;
            a = m_start + 10'(k);
            if (!dropped) begin
                if (acc > int'(MAXB) || 10'(a + 10'd1) == commited_rd_address) dropped = 1'b1;
                else exp_q.push_back('{1'b0, a, d});
            end
        end
        if (abort_words > 0) begin
            do_reset();
            return;
        end
        @(negedge clk156);
        rx_data_valid = 8'd0;
        rx_data       = {$urandom, $urandom};
        repeat ($urandom_range(0, 2)) @(negedge clk156);
        @(negedge clk156);
        rx_good_frame = good;
        rx_bad_frame  = !good;
        if (!dropped && good) begin
            exp_q.push_back('{1'b0, m_start, 64'(16'(nbytes))});
            m_start = m_start + 10'(nw + 1);
            exp_q.push_back('{1'b1, m_start, 64'd0});
        end else begin
            m_drops++;
        end
        @(negedge clk156);
        rx_good_frame = 1'b0;
        rx_bad_frame  = 1'b0;
        repeat (3) @(posedge clk156);
        #1;
        check("dropped_frames", 64'(dropped_frames), 64'(exp_drops()));
    endtask

    initial begin
        int n;
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n             = 1'b0;
        rx_data             = 64'd0;
        rx_data_valid       = 8'd0;
        rx_good_frame       = 1'b0;
        rx_bad_frame        = 1'b0;
        commited_rd_address = 10'd0;
        do_reset();

        send_frame(64, 1'b1, 0);
        check("commit_after_64", 64'(commited_wr_address), 64'd9);
        commited_rd_address = 10'd9;
        send_frame(61, 1'b1, 0);
        check("commit_after_61", 64'(commited_wr_address), 64'd18);
        commited_rd_address = 10'd18;
        send_frame(64, 1'b0, 0);
        send_frame(64, 1'b1, 0);
        check("commit_after_rollback", 64'(commited_wr_address), 64'd27);
        commited_rd_address = 10'd27;
        send_frame(1600, 1'b1, 0);
        check("oversize_no_commit", 64'(commited_wr_address), 64'd27);
        send_frame(200, 1'b1, 5);

        commited_rd_address = 10'd20;
        send_frame(200, 1'b1, 0);
        check("nofit_no_commit", 64'(commited_wr_address), 64'd0);
        commited_rd_address = 10'd0;
        send_frame(64, 1'b1, 0);
        check("commit_after_advance", 64'(commited_wr_address), 64'd9);

        do_reset();
        for (int i = 0; i < 113; i++) begin
            commited_rd_address = m_start;
            send_frame(64, 1'b1, 0);
        end
        commited_rd_address = m_start;
        send_frame(16, 1'b1, 0);
        check("start_1020", 64'(commited_wr_address), 64'd1020);
        commited_rd_address = 10'd600;
        send_frame(64, 1'b1, 0);
        check("commit_after_wrap", 64'(commited_wr_address), 64'd5);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 3) commited_rd_address = m_start + 10'($urandom_range(2, 300));
            else commited_rd_address = m_start;
            n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1400, 1700)) : int'($urandom_range(1, 400));
            send_frame(n, $urandom_range(0, 9) < 8, 0);
        end

        repeat (5) @(posedge clk156);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
